// File: rtl/riscv_fetch_pkg.sv
// riscv_fetch_pkg: shared fetch-path entry types and constants
package riscv_fetch_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;
    typedef struct packed {
        logic            epoch;
        logic [XLEN-1:0] pc;
    } pend_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular FIFO with registered storage and synchronous clear
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign empty   = count == '0;
    assign full    = count == (AW+1)'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: credit-limited in-order instruction fetch with epoch-based flush
module instr_fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FQ_DEPTH   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] pc_in,
    output logic                  pc_write,
    input  logic                  flush,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    output logic                  if_valid,
    input  logic                  if_ready,
    output logic [DATA_WIDTH-1:0] if_pc,
    output logic [DATA_WIDTH-1:0] if_instr
);
    localparam int CW = $clog2(FQ_DEPTH) + 1;
    logic          epoch;
    logic [CW-1:0] outstanding, fq_count, pend_count, used;
    logic          pend_empty, pend_full, fq_empty, fq_full;
    logic          rsp_pop, fq_push, fq_pop, credit_ok;
    pend_entry_t   pend_in, pend_head;
    fetch_entry_t  fq_in, fq_head;
    logic          unused;
    assign fq_pop         = !fq_empty && if_ready;
    // Buffered plus in-flight work may never exceed the queue, so responses need no backpressure
    assign used           = outstanding + fq_count - CW'(fq_pop);
    assign credit_ok      = used < CW'(FQ_DEPTH);
    assign imem_req_valid = rst_n && !flush && credit_ok;
    assign imem_req_addr  = pc_in;
    assign pc_write       = imem_req_valid && imem_req_ready;
    assign rsp_pop        = imem_rsp_valid && !pend_empty;
    assign fq_push        = rsp_pop && pend_head.epoch == epoch && !flush;
    assign pend_in        = '{epoch: epoch, pc: pc_in};
    assign fq_in          = '{pc: pend_head.pc, instr: imem_rsp_data};
    assign if_valid       = !fq_empty;
    assign if_pc          = fq_empty ? '0 : fq_head.pc;
    assign if_instr       = fq_empty ? NOP_INSTR : fq_head.instr;
    assign unused         = &{1'b0, pend_count, pend_full, fq_full};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            epoch       <= 1'b0;
            outstanding <= '0;
        end else begin
            if (flush) epoch <= ~epoch;
            outstanding <= outstanding + CW'(pc_write) - CW'(rsp_pop);
        end
    end
    fetch_fifo #(.WIDTH($bits(pend_entry_t)), .DEPTH(FQ_DEPTH)) u_pend_q (
        .clk(clk), .rst_n(rst_n), .clr(1'b0),
        .push(pc_write), .din(pend_in), .pop(rsp_pop), .dout(pend_head),
        .count(pend_count), .empty(pend_empty), .full(pend_full)
    );
    fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FQ_DEPTH)) u_fetch_q (
        .clk(clk), .rst_n(rst_n), .clr(flush),
        .push(fq_push), .din(fq_in), .pop(fq_pop), .dout(fq_head),
        .count(fq_count), .empty(fq_empty), .full(fq_full)
    );
`ifdef SIMULATION
    always_ff @(posedge clk) begin
        if (rst_n && imem_rsp_valid && pend_empty) $error("imem response with no pending request");
        if (rst_n) assert (!(fq_push && fq_full && !fq_pop)) else $error("fetch queue overflow");
    end
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;
    import riscv_fetch_pkg::*;
    localparam int D = 2;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] pc_in = '0, imem_req_addr, imem_rsp_data = '0, if_pc, if_instr;
    logic        pc_write, flush = 1'b0, imem_req_valid, imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0, if_valid, if_ready = 1'b0;
    instr_fetch_unit #(.DATA_WIDTH(32), .FQ_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .pc_write(pc_write), .flush(flush),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .if_valid(if_valid), .if_ready(if_ready),
        .if_pc(if_pc), .if_instr(if_instr)
    );
    always #5 clk = ~clk;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
    typedef struct { logic [31:0] addr; int due; int gen; } mreq_t;
    exp_t  exp_q[$];
    mreq_t mq[$];
    int vectors = 0, miscompares = 0, cyc = 0, issued = 0, gen = 0;
    int p_rdy = 100, p_ifr = 100, p_fl = 0, lat_lo = 1, lat_hi = 1;
    logic [31:0] flush_tgt = '0;
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h00000013;
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask
    task automatic check_reset();
        chk("rst_req_valid", 32'(imem_req_valid), 0);
        chk("rst_pc_write", 32'(pc_write), 0);
        chk("rst_if_valid", 32'(if_valid), 0);
        chk("rst_if_pc", if_pc, 0);
        chk("rst_if_instr", if_instr, NOP_INSTR);
    endtask
    // One clock: record this cycle's handshakes, then drive the next cycle's inputs
    task automatic step();
        bit hs, fl;
        @(negedge clk);
        hs = 1'b0;
        fl = 1'b0;
        if (rst_n) begin
            hs = imem_req_valid && imem_req_ready;
            fl = flush;
            chk("req_addr", imem_req_addr, pc_in);
            chk("pc_write", 32'(pc_write), 32'(hs));
            if (fl) begin
                chk("req_valid_in_flush", 32'(imem_req_valid), 0);
                exp_q.delete();
                gen++;
            end else if (hs) begin
                exp_q.push_back('{pc_in, mem_word(pc_in)});
                mq.push_back('{pc_in, cyc + int'($urandom_range(lat_hi, lat_lo)), gen});
                issued++;
                chk("credit_limit", 32'(mq.size() <= D), 1);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (fl) pc_in = flush_tgt;
        else if (hs) pc_in = pc_in + 32'd4;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        imem_req_ready = $urandom_range(99) < p_rdy;
        if_ready       = $urandom_range(99) < p_ifr;
        // only flush once every older-generation request has returned
        flush     = ($urandom_range(99) < p_fl) && (mq.size() == 0 || mq[0].gen == gen);
        flush_tgt = {22'b0, 8'($urandom_range(255)), 2'b00};
    endtask
    // Monitor: pops the scoreboard on every accepted instruction and checks stall stability
    initial begin
        exp_t e;
        bit stall_prev = 1'b0;
        logic [31:0] prev_pc = '0, prev_instr = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 1'b0;
                continue;
            end
            if (stall_prev) begin
                chk("stall_pc_stable", if_pc, prev_pc);
                chk("stall_instr_stable", if_instr, prev_instr);
            end
            if (if_valid && if_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_delivery: got pc %h expected nothing", if_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("if_pc", if_pc, e.pc);
                    chk("if_instr", if_instr, e.instr);
                end
            end
            stall_prev = if_valid && !if_ready && !flush;
            prev_pc    = if_pc;
            prev_instr = if_instr;
        end
    end
    initial begin
        logic [31:0] held;
        int n;
        repeat (2) @(posedge clk);
        #1;
        check_reset();
        imem_req_ready = 1'b1;
        if_ready = 1'b1;
        cyc = 0;
        rst_n = 1'b1;
        step();
        chk("t1_not_yet_valid", 32'(if_valid), 0);
        step();
        chk("t1_min_latency_valid", 32'(if_valid), 1);
        chk("t1_first_pc", if_pc, 0);
        repeat (10) step();
        p_ifr = 0;
        step();
        issued = 0;
        repeat (10) step();
        chk("t2_issue_cap", 32'(issued <= D), 1);
        chk("t2_pc_write_idle", 32'(pc_write), 0);
        chk("t2_still_valid", 32'(if_valid), 1);
        p_ifr = 100;
        repeat (10) step();
        lat_lo = 4;
        lat_hi = 4;
        n = 0;
        while (mq.size() < 2 && n < 20) begin step(); n++; end
        chk("t3_two_outstanding", 32'(mq.size()), 2);
        flush = 1'b1;
        flush_tgt = 32'h40;
        step();
        chk("t3_valid_after_flush", 32'(if_valid), 0);
        n = 0;
        while (!if_valid && n < 20) begin step(); n++; end
        chk("t3_first_pc_after_flush", if_pc, 32'h40);
        lat_lo = 1;
        lat_hi = 1;
        p_rdy = 0;
        repeat (8) step();
        held = imem_req_addr;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_req_valid_held", 32'(imem_req_valid), 1);
            chk("t4_addr_stable", imem_req_addr, held);
            chk("t4_pc_write_low", 32'(pc_write), 0);
        end
        p_rdy = 100;
        n = 0;
        do begin step(); n++; end while (!(imem_rsp_valid && if_valid && if_ready) && n < 30);
        chk("t5_rsp_and_if_hs_found", 32'(imem_rsp_valid && if_valid && if_ready), 1);
        flush = 1'b1;
        flush_tgt = 32'h100;
        step();
        chk("t5_queue_empty_after_flush", 32'(if_valid), 0);
        repeat (6) step();
        p_rdy = 0;
        repeat (8) step();
        lat_lo = 3;
        lat_hi = 3;
        imem_req_ready = 1'b1;
        step();
        step();
        chk("t6_one_outstanding", 32'(mq.size()), 1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_reset();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t6_late_rsp_ignored", 32'(if_valid), 0);
        end
        chk("t6_late_rsp_delivered", 32'(mq.size()), 0);
        p_rdy = 70;
        p_ifr = 60;
        p_fl = 3;
        lat_lo = 1;
        lat_hi = 4;
        repeat (3000) step();
        p_fl = 0;
        p_rdy = 0;
        p_ifr = 100;
        repeat (20) step();
        chk("drain_scoreboard_empty", 32'(exp_q.size()), 0);
        chk("drain_memory_idle", 32'(mq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
